// File: rtl/decode_stage_if.sv
// Fetch/write-back inputs and ID/EX outputs of the decode stage, bundled.
// Handshake: fetch presents an instruction with if_valid=1 and must hold it
// unchanged while stall_out=1; the instruction is consumed on the first
// rising edge where stall_out=0 (or is discarded by flush).
interface decode_stage_if;
    logic        if_valid;
    logic [5:0]  if_opcode;
    logic [2:0]  if_src;
    logic [2:0]  if_dst;
    logic [3:0]  if_shamt;
    logic        flush;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        stall_out;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [2:0]  id_dst;
    logic [3:0]  id_shamt;
    logic [15:0] id_rs_val;
    logic [15:0] id_rd_val;
    logic [1:0]  id_alu_op;
    logic        id_mem_rd;
    logic        id_mem_wr;
    logic        id_reg_wr;
    logic        id_illegal;
    logic [15:0] id_count;

    // Driver side: fetch stage, write-back and pipeline control.
    modport master (
        output if_valid, if_opcode, if_src, if_dst, if_shamt, flush,
               wb_en, wb_addr, wb_data,
        input  stall_out, id_valid, id_opcode, id_dst, id_shamt,
               id_rs_val, id_rd_val, id_alu_op, id_mem_rd, id_mem_wr,
               id_reg_wr, id_illegal, id_count
    );

    // Decode stage side.
    modport slave (
        input  if_valid, if_opcode, if_src, if_dst, if_shamt, flush,
               wb_en, wb_addr, wb_data,
        output stall_out, id_valid, id_opcode, id_dst, id_shamt,
               id_rs_val, id_rd_val, id_alu_op, id_mem_rd, id_mem_wr,
               id_reg_wr, id_illegal, id_count
    );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: opcode decode, 8x16 register file with
// write-through bypass, load-use hazard detection and the ID/EX register.
module decode_stage (
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave bus
);
    localparam logic [5:0] OP_ADD = 6'b000011;
    localparam logic [5:0] OP_NOT = 6'b000100;
    localparam logic [5:0] OP_NOP = 6'b000101;
    localparam logic [5:0] OP_LDD = 6'b010001;
    localparam logic [5:0] OP_STD = 6'b010010;

    logic [15:0] regs [8];

    logic [1:0]  dec_alu_op;
    logic        dec_mem_rd;
    logic        dec_mem_wr;
    logic        dec_reg_wr;
    logic        dec_illegal;
    logic        use_src;
    logic        use_dst;
    logic [15:0] rs_val;
    logic [15:0] rd_val;
    logic        hazard;
    logic        stall;
    logic        load_bubble;

    logic        r_valid;
    logic [5:0]  r_opcode;
    logic [2:0]  r_dst;
    logic [3:0]  r_shamt;
    logic [15:0] r_rs_val;
    logic [15:0] r_rd_val;
    logic [1:0]  r_alu_op;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic        r_reg_wr;
    logic        r_illegal;
    logic [15:0] r_count;

    // Opcode table: control flags and which register operands are read.
    always_comb begin
        dec_alu_op  = 2'b00;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_reg_wr  = 1'b0;
        dec_illegal = 1'b0;
        use_src     = 1'b0;
        use_dst     = 1'b0;
        case (bus.if_opcode)
            OP_ADD: begin dec_alu_op = 2'b01; dec_reg_wr = 1'b1; use_src = 1'b1; use_dst = 1'b1; end
            OP_NOT: begin dec_alu_op = 2'b10; dec_reg_wr = 1'b1; use_dst = 1'b1; end
            OP_NOP: ;
            OP_LDD: begin dec_mem_rd = 1'b1; dec_reg_wr = 1'b1; use_src = 1'b1; end
            OP_STD: begin dec_mem_wr = 1'b1; use_src = 1'b1; use_dst = 1'b1; end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Read ports see a same-cycle write to the addressed register.
    assign rs_val = (bus.wb_en && bus.wb_addr == bus.if_src) ? bus.wb_data : regs[bus.if_src];
    assign rd_val = (bus.wb_en && bus.wb_addr == bus.if_dst) ? bus.wb_data : regs[bus.if_dst];

    // Load-use hazard: a load in ID/EX whose destination the incoming
    // instruction reads. The bubble clears id_mem_rd, so it lasts one cycle.
    assign hazard = r_valid && r_mem_rd && bus.if_valid &&
                    ((use_src && bus.if_src == r_dst) || (use_dst && bus.if_dst == r_dst));
    assign stall       = hazard && !bus.flush && rst_n;
    assign load_bubble = bus.flush || stall || !bus.if_valid;
    assign bus.stall_out = stall;

    // Register file write port; writes ignore stall and flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else if (bus.wb_en) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // ID/EX register: loads a decoded instruction or a bubble every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || load_bubble) begin
            r_valid   <= 1'b0;
            r_opcode  <= 6'd0;
            r_dst     <= 3'd0;
            r_shamt   <= 4'd0;
            r_rs_val  <= 16'h0000;
            r_rd_val  <= 16'h0000;
            r_alu_op  <= 2'b00;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_reg_wr  <= 1'b0;
            r_illegal <= 1'b0;
            if (!rst_n) r_count <= 16'h0000;
        end else begin
            r_valid   <= 1'b1;
            r_opcode  <= bus.if_opcode;
            r_dst     <= bus.if_dst;
            r_shamt   <= bus.if_shamt;
            r_rs_val  <= rs_val;
            r_rd_val  <= rd_val;
            r_alu_op  <= dec_alu_op;
            r_mem_rd  <= dec_mem_rd;
            r_mem_wr  <= dec_mem_wr;
            r_reg_wr  <= dec_reg_wr;
            r_illegal <= dec_illegal;
            r_count   <= r_count + 16'd1;
        end
    end

    assign bus.id_valid   = r_valid;
    assign bus.id_opcode  = r_opcode;
    assign bus.id_dst     = r_dst;
    assign bus.id_shamt   = r_shamt;
    assign bus.id_rs_val  = r_rs_val;
    assign bus.id_rd_val  = r_rd_val;
    assign bus.id_alu_op  = r_alu_op;
    assign bus.id_mem_rd  = r_mem_rd;
    assign bus.id_mem_wr  = r_mem_wr;
    assign bus.id_reg_wr  = r_reg_wr;
    assign bus.id_illegal = r_illegal;
    assign bus.id_count   = r_count;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// instruction streams against a cycle-level behavioural model.
module tb_decode_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic seen_stall;

    decode_stage_if bus();

    decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_regs [8];
    logic        m_valid;
    logic [5:0]  m_opcode;
    logic [2:0]  m_dst;
    logic [3:0]  m_shamt;
    logic [15:0] m_rs, m_rd, m_count;
    logic [1:0]  m_alu;
    logic        m_mem_rd, m_mem_wr, m_reg_wr, m_ill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic reads_src(input logic [5:0] op);
        return op == 6'b000011 || op == 6'b010010 || op == 6'b010001;
    endfunction

    function automatic logic reads_dst(input logic [5:0] op);
        return op == 6'b000011 || op == 6'b010010 || op == 6'b000100;
    endfunction

    // One clock cycle: drive, check stall_out, advance model, check ID/EX.
    task automatic step(input logic rst, input logic v, input logic [5:0] op,
                        input logic [2:0] s, input logic [2:0] d, input logic [3:0] sh,
                        input logic fl, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd);
        logic e_stall;
        @(negedge clk);
        rst_n         = rst;
        bus.if_valid  = v;
        bus.if_opcode = op;
        bus.if_src    = s;
        bus.if_dst    = d;
        bus.if_shamt  = sh;
        bus.flush     = fl;
        bus.wb_en     = we;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        #1;
        e_stall = rst && !fl && v && m_valid && m_mem_rd &&
                  ((reads_src(op) && s == m_dst) || (reads_dst(op) && d == m_dst));
        seen_stall = bus.stall_out;
        check("stall_out", {31'd0, bus.stall_out}, {31'd0, e_stall});

        if (!rst) begin
            m_valid = 0; m_opcode = 0; m_dst = 0; m_shamt = 0; m_rs = 0; m_rd = 0;
            m_alu = 0; m_mem_rd = 0; m_mem_wr = 0; m_reg_wr = 0; m_ill = 0; m_count = 0;
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        end else begin
            if (fl || e_stall || !v) begin
                m_valid = 0; m_alu = 0; m_mem_rd = 0; m_mem_wr = 0; m_reg_wr = 0; m_ill = 0;
            end else begin
                m_valid  = 1;
                m_opcode = op;
                m_dst    = d;
                m_shamt  = sh;
                m_rs     = (we && wa == s) ? wd : m_regs[s];
                m_rd     = (we && wa == d) ? wd : m_regs[d];
                m_alu = 0; m_mem_rd = 0; m_mem_wr = 0; m_reg_wr = 0; m_ill = 0;
                case (op)
                    6'b000011: begin m_alu = 2'b01; m_reg_wr = 1; end
                    6'b000100: begin m_alu = 2'b10; m_reg_wr = 1; end
                    6'b000101: ;
                    6'b010001: begin m_mem_rd = 1; m_reg_wr = 1; end
                    6'b010010: m_mem_wr = 1;
                    default:   m_ill = 1;
                endcase
                m_count = m_count + 16'd1;
            end
            if (we) m_regs[wa] = wd;
        end

        @(posedge clk);
        #1;
        check("id_valid",   {31'd0, bus.id_valid},   {31'd0, m_valid});
        check("id_alu_op",  {30'd0, bus.id_alu_op},  {30'd0, m_alu});
        check("id_mem_rd",  {31'd0, bus.id_mem_rd},  {31'd0, m_mem_rd});
        check("id_mem_wr",  {31'd0, bus.id_mem_wr},  {31'd0, m_mem_wr});
        check("id_reg_wr",  {31'd0, bus.id_reg_wr},  {31'd0, m_reg_wr});
        check("id_illegal", {31'd0, bus.id_illegal}, {31'd0, m_ill});
        check("id_count",   {16'd0, bus.id_count},   {16'd0, m_count});
        if (m_valid || !rst) begin
            check("id_opcode", {26'd0, bus.id_opcode}, {26'd0, m_opcode});
            check("id_dst",    {29'd0, bus.id_dst},    {29'd0, m_dst});
            check("id_shamt",  {28'd0, bus.id_shamt},  {28'd0, m_shamt});
            check("id_rs_val", {16'd0, bus.id_rs_val}, {16'd0, m_rs});
            check("id_rd_val", {16'd0, bus.id_rd_val}, {16'd0, m_rd});
        end
    endtask

    task automatic idle_wb(input logic [2:0] wa, input logic [15:0] wd);
        step(1, 0, 6'b000101, 0, 0, 0, 0, 1, wa, wd);
    endtask

    // Stimulus and directed scenarios
    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        checks = 0;
        failures = 0;
        ops[0] = 6'b000011; ops[1] = 6'b000100; ops[2] = 6'b000101;
        ops[3] = 6'b010001; ops[4] = 6'b010010; ops[5] = 6'b000000;

        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 6'b000011, 1, 2, 3, 0, 1, 3, 16'h1234);
        check("rst_valid", {31'd0, bus.id_valid}, 32'd0);
        check("rst_count", {16'd0, bus.id_count}, 32'd0);

        // ADD after write-back
        idle_wb(1, 16'h0005);
        idle_wb(2, 16'h0003);
        step(1, 1, 6'b000011, 2, 1, 0, 0, 0, 0, 0);
        check("add_rs",  {16'd0, bus.id_rs_val}, 32'h0003);
        check("add_rd",  {16'd0, bus.id_rd_val}, 32'h0005);
        check("add_alu", {30'd0, bus.id_alu_op}, 32'd1);
        check("add_wr",  {31'd0, bus.id_reg_wr}, 32'd1);

        // Load-use hazard: one stall, one bubble, then ADD issues
        step(1, 1, 6'b010001, 7, 1, 0, 0, 0, 0, 0);
        step(1, 1, 6'b000011, 2, 1, 0, 0, 0, 0, 0);
        check("haz_stall",  {31'd0, seen_stall},    32'd1);
        check("haz_bubble", {31'd0, bus.id_valid},  32'd0);
        step(1, 1, 6'b000011, 2, 1, 0, 0, 0, 0, 0);
        check("haz_nostall", {31'd0, seen_stall},    32'd0);
        check("haz_issue",   {31'd0, bus.id_valid},  32'd1);
        check("haz_alu",     {30'd0, bus.id_alu_op}, 32'd1);

        // Flush in the hazard cycle
        step(1, 1, 6'b010001, 7, 1, 0, 0, 0, 0, 0);
        step(1, 1, 6'b000011, 2, 1, 0, 1, 0, 0, 0);
        check("fl_stall",  {31'd0, seen_stall},   32'd0);
        check("fl_bubble", {31'd0, bus.id_valid}, 32'd0);
        step(1, 0, 6'b000011, 2, 1, 0, 0, 0, 0, 0);
        check("fl_noissue", {31'd0, bus.id_valid}, 32'd0);

        // Write-through bypass
        step(1, 1, 6'b000100, 0, 3, 0, 0, 1, 3, 16'hABCD);
        check("byp_rd", {16'd0, bus.id_rd_val}, 32'h0000ABCD);

        // Illegal opcode
        step(1, 1, 6'b111111, 1, 2, 5, 0, 0, 0, 0);
        check("ill_flag",  {31'd0, bus.id_illegal}, 32'd1);
        check("ill_valid", {31'd0, bus.id_valid},   32'd1);
        check("ill_ctrl",  {27'd0, bus.id_alu_op, bus.id_mem_rd, bus.id_mem_wr, bus.id_reg_wr}, 32'd0);

        // Randomized streams; small register range makes hazards frequent
        for (int n = 0; n < 3000; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            step($urandom_range(0, 63) != 0, $urandom_range(0, 5) != 0, op,
                 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 4'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                 3'($urandom_range(0, 7)), 16'($urandom));
        end

        // Count wrap: 65535 issues, then one more
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 65535; n++) step(1, 1, 6'b000101, 0, 0, 0, 0, 0, 0, 0);
        check("cnt_ffff", {16'd0, bus.id_count}, 32'h0000FFFF);
        step(1, 1, 6'b000101, 0, 0, 0, 0, 0, 0, 0);
        check("cnt_wrap", {16'd0, bus.id_count}, 32'h00000000);

        // Reset in the hazard cycle, then the held ADD decodes
        step(1, 1, 6'b010001, 7, 1, 0, 0, 0, 0, 0);
        step(0, 1, 6'b000011, 2, 1, 0, 0, 0, 0, 0);
        check("rs_stall", {31'd0, seen_stall}, 32'd0);
        check("rs_outs",  {bus.id_valid, bus.id_mem_rd, bus.id_reg_wr, bus.id_alu_op, bus.id_count}, 32'd0);
        step(1, 1, 6'b000011, 2, 1, 0, 0, 0, 0, 0);
        check("rs_issue", {31'd0, bus.id_valid}, 32'd1);
        check("rs_cnt",   {16'd0, bus.id_count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset; ports are listed clock and reset first.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 if_valid  input  1  fetch presents a valid instruction this cycle.
REQ-005 if_opcode  input  6  instruction bits [15:10].
REQ-006 if_src  input  3  source register index, bits [9:7].
REQ-007 if_dst  input  3  destination register index, bits [6:4].
REQ-008 if_shamt  input  4  shift amount, bits [3:0].
REQ-009 flush  input  1  discard the instruction being decoded.
REQ-010 wb_en, wb_addr, wb_data  input  1/3/16  register-file write-back port.
REQ-011 stall_out  output  1  combinational; fetch SHALL hold its outputs while high.
REQ-012 id_valid  output  1  ID/EX register holds a real instruction.
REQ-013 id_opcode/id_dst/id_shamt  output  6/3/4  registered copies of the decoded fields.
REQ-014 id_rs_val, id_rd_val  output  16 each  operand values read for src and dst.
REQ-015 id_alu_op  output  2  00 pass, 01 add, 10 not.
REQ-016 id_mem_rd, id_mem_wr, id_reg_wr, id_illegal  output  1 each  control flags.
REQ-017 id_count  output  16  count of instructions issued with id_valid=1.

Function
REQ-018 The opcode table SHALL be: 000011 ADD (alu 01, reg_wr), 000100 NOT (alu 10, reg_wr), 000101 NOP (alu 00, no flags), 010001 LDD (mem_rd, reg_wr), 010010 STD (mem_wr).
REQ-019 Any other opcode SHALL decode as NOP with id_illegal=1 and id_valid=1.
REQ-020 Register file: 8 x 16 bits, one write port (wb_*) and two read ports (if_src, if_dst).
REQ-021 A write to the register file SHALL occur on the rising edge when wb_en=1.
REQ-022 Same-cycle read of wb_addr with wb_en=1 SHALL return wb_data (write-through bypass).
REQ-023 The ID/EX register SHALL update every cycle; latency from fetch fields to id_* is exactly 1 cycle.
REQ-024 Operand usage: ADD and STD use src and dst; NOT uses dst; LDD uses src; NOP/illegal use none.
REQ-025 stall_out SHALL be 1 when all of the following hold:
  - id_valid=1 and id_mem_rd=1;
  - if_valid=1;
  - the incoming instruction uses a register equal to id_dst.
REQ-026 While stall_out=1, the ID/EX register SHALL load a bubble: id_valid=0 and all control flags 0.
REQ-027 After a stall, the held instruction SHALL decode on the next cycle; at most one bubble is inserted per hazard.
REQ-028 if_valid=0 SHALL produce a bubble and stall_out=0.
REQ-029 flush=1 SHALL load a bubble and force stall_out=0, overriding a hazard in the same cycle.
REQ-030 id_count SHALL increment by 1 on each edge that loads id_valid=1, and wrap from FFFF to 0000.
REQ-031 Register-file writes SHALL proceed regardless of stall or flush.

Reset
REQ-032 While rst_n=0 at a rising edge:
  - every id_* output and id_count clear to 0;
  - all 8 registers clear to 0000.
REQ-033 stall_out SHALL be 0 during reset.
REQ-034 Reset asserted mid-stall SHALL discard the stalled instruction; the first cycle after reset decodes the fetch inputs then present.

Verification
REQ-035 Reset, then wb writes r1=0005 and r2=0003, then ADD src=2 dst=1 -> next cycle id_rs_val=0003, id_rd_val=0005, id_alu_op=01, id_reg_wr=1.
REQ-036 LDD src=7 dst=1 followed by ADD src=2 dst=1 -> stall_out=1 for one cycle, one bubble (id_valid=0), then ADD issues.
REQ-037 Same sequence with flush=1 in the hazard cycle -> stall_out=0, bubble, ADD not issued.
REQ-038 wb_en=1, wb_addr=3, wb_data=ABCD in the same cycle as NOT dst=3 -> id_rd_val=ABCD.
REQ-039 opcode 111111 -> id_illegal=1, id_valid=1, all other control flags 0.
REQ-040 Preload id_count=FFFF by 65535 valid issues, then issue one more -> id_count=0000; assert rst_n=0 mid-stall -> all outputs 0.
